// File: rtl/data_mem_access.sv
// MEM-stage data memory access unit: turns a pipeline load/store into one bus transaction.
// Latency: aligned access stalls N+1 cycles (ack on Nth bus cycle); misaligned access stalls 1 cycle.
// Backpressure: holds StallM high until bus_ack or the wait limit; one DONE cycle then releases.
module data_mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] DM_RD,
  output logic        StallM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        AlignErr,
  output logic        TimeoutErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the last bus cycle we are willing to wait.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] data_q;
  logic        access;
  logic        aligned;
  logic        limit_hit;

  assign access    = MemReadM | MemWriteM;
  assign aligned   = (ALUOutM[1:0] == 2'b00);
  assign limit_hit = (wait_cnt == WAIT_LIMIT);

  // Address and data come straight from the EX/MEM register, which the stall holds stable.
  assign bus_addr  = {ALUOutM[31:2], 2'b00};
  assign bus_wdata = WriteDataM;
  assign DM_RD     = data_q;

  // Next-state decode and the combinational stall request (forced low while in reset).
  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    case (state)
      IDLE: begin
        StallM = access & RST;
        if (access) begin
          state_nxt = aligned ? REQ : DONE;
        end
      end
      REQ: begin
        StallM = RST;
        // An ack on the limit cycle still counts as a successful completion.
        if (bus_ack || limit_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus bus strobes decoded from the next state so they come straight off flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      bus_req <= 1'b0;
      bus_we  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_req <= (state_nxt == REQ);
      bus_we  <= (state_nxt == REQ) & MemWriteM;
    end
  end

  // Bus wait counter: zero outside REQ, counts REQ cycles that see no ack.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt <= 8'd0;
    end else if (state != REQ) begin
      wait_cnt <= 8'd0;
    end else if (!bus_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Result register and sticky error flags, updated only when an access completes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q     <= 32'd0;
      AlignErr   <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A misaligned access completes without touching the bus and returns zero.
          if (access && !aligned) begin
            data_q   <= 32'd0;
            AlignErr <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ack) begin
            // Read+write together is handled as a store, so no read data comes back.
            data_q <= MemWriteM ? 32'd0 : bus_rdata;
          end else if (limit_hit) begin
            data_q     <= TIMEOUT_DATA;
            TimeoutErr <= 1'b1;
          end
        end
        default: begin
          data_q <= data_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: directed vector table, reset corner cases, then random accesses
// checked against a transaction-level model of stall length, bus cycles, result and error flags.
// Bus responder acks on a chosen REQ cycle (0 = never).
module tb_data_mem_access;

  localparam int TMO = 16;

  logic        CLK;
  logic        RST;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] DM_RD;
  logic        StallM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        AlignErr;
  logic        TimeoutErr;

  int pass_cnt = 0;
  int total_cnt = 0;

  data_mem_access #(.TIMEOUT(TMO)) dut (
    .CLK(CLK),
    .RST(RST),
    .MemReadM(MemReadM),
    .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM),
    .DM_RD(DM_RD),
    .StallM(StallM),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
    .AlignErr(AlignErr),
    .TimeoutErr(TimeoutErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_n;
    logic [31:0] rdata;
    logic [31:0] exp_dm;
    int          exp_stall;
    int          exp_breq;
    logic        exp_aerr;
    logic        exp_terr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one pipeline access from IDLE through DONE; returns what was observed.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_n, input logic [31:0] rdata,
                           output int stall_c, output int breq_c, output int idle_c,
                           output logic [31:0] dm, output logic we_ok, output logic addr_ok);
    int  reqseen;
    int  cyc;
    bit  done;
    reqseen = 0; cyc = 0; done = 0;
    stall_c = 0; breq_c = 0; idle_c = 0; dm = 32'hx; we_ok = 1'b1; addr_ok = 1'b1;
    MemReadM = rd; MemWriteM = wr; ALUOutM = addr; WriteDataM = wdata;
    while (!done && cyc < TMO + 8) begin
      @(negedge CLK);
      cyc++;
      if (bus_req) begin
        reqseen++;
        breq_c++;
        if (bus_we !== wr) we_ok = 1'b0;
        if (bus_addr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
        if (wr && bus_wdata !== wdata) addr_ok = 1'b0;
        if (reqseen == ack_n) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
      end
      if (StallM) begin
        stall_c++;
        if (!bus_req) idle_c++;
      end else begin
        done = 1;
        dm = DM_RD;
      end
      @(posedge CLK);
      #1;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
    end
    if (!done) chk("access_hang", 32'd0, 32'd1);
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  // Transaction-level expectation from the access rules.
  function automatic void model(input logic wr, input logic [31:0] addr, input int ack_n,
                                input logic [31:0] rdata, output logic [31:0] dm,
                                output int stall, output int breq, output logic misal,
                                output logic tmo);
    misal = (addr % 4) != 0;
    tmo   = !misal && !(ack_n >= 1 && ack_n <= TMO);
    if (misal) breq = 0;
    else if (tmo) breq = TMO;
    else breq = ack_n;
    stall = breq + 1;
    if (misal) dm = 32'd0;
    else if (tmo) dm = 32'hDEAD_BEEF;
    else if (wr) dm = 32'd0;
    else dm = rdata;
  endfunction

  initial begin
    int          st, bq, id;
    logic [31:0] dm;
    logic        wok, aok;
    logic [31:0] e_dm;
    int          e_st, e_bq;
    logic        e_mis, e_tmo;
    logic        m_aerr, m_terr;

    //            rd    wr    addr          wdata          ack rdata          exp_dm         st  bq  aerr  terr
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        3,  32'h1234_5678, 32'h1234_5678, 4,  3,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h7777_7777, 32'h0,         2,  1,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        1,  32'h5555_5555, 32'h0,         1,  0,  1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1,  32'h1111_0040, 32'h1111_0040, 2,  1,  1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        1,  32'h2222_0044, 32'h2222_0044, 2,  1,  1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0048, 32'h55AA_55AA, 2, 32'h9999_9999, 32'h0,         3,  2,  1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        16, 32'h0BAD_F00D, 32'h0BAD_F00D, 17, 16, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        0,  32'h0,         32'hDEAD_BEEF, 17, 16, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        2,  32'h7654_3210, 32'h7654_3210, 3,  2,  1'b1, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 32'h0000_0022, 32'h1234_0000, 1, 32'h0,         32'h0,         1,  0,  1'b1, 1'b1};

    // Reset state with an access already presented.
    RST = 1'b0; MemReadM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h10; WriteDataM = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_dm", DM_RD, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_breq", {31'd0, bus_req}, 32'd0);
    chk("rst_bwe", {31'd0, bus_we}, 32'd0);
    chk("rst_errs", {30'd0, AlignErr, TimeoutErr}, 32'd0);
    MemReadM = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Directed table, applied back-to-back.
    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_n,
                vecs[i].rdata, st, bq, id, dm, wok, aok);
      chk($sformatf("v%0d_dm", i), dm, vecs[i].exp_dm);
      chk($sformatf("v%0d_stall", i), st, vecs[i].exp_stall);
      chk($sformatf("v%0d_breq", i), bq, vecs[i].exp_breq);
      chk($sformatf("v%0d_idle", i), id, 32'd1);
      chk($sformatf("v%0d_we", i), {31'd0, wok}, 32'd1);
      chk($sformatf("v%0d_addr", i), {31'd0, aok}, 32'd1);
      chk($sformatf("v%0d_aerr", i), {31'd0, AlignErr}, {31'd0, vecs[i].exp_aerr});
      chk($sformatf("v%0d_terr", i), {31'd0, TimeoutErr}, {31'd0, vecs[i].exp_terr});
    end

    // Reset pulsed during the second REQ cycle of a load.
    do_access(1'b1, 1'b0, 32'h300, 32'h0, 1, 32'hA5A5_A5A5, st, bq, id, dm, wok, aok);
    chk("pre_rst_dm", dm, 32'hA5A5_A5A5);
    MemReadM = 1'b1; ALUOutM = 32'h200;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_req_breq", {31'd0, bus_req}, 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_dm", DM_RD, 32'd0);
    chk("mid_rst_stall", {31'd0, StallM}, 32'd0);
    chk("mid_rst_breq", {31'd0, bus_req}, 32'd0);
    chk("mid_rst_bwe", {31'd0, bus_we}, 32'd0);
    chk("mid_rst_errs", {30'd0, AlignErr, TimeoutErr}, 32'd0);
    MemReadM = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst_stall", {31'd0, StallM}, 32'd0);
    chk("post_rst_breq", {31'd0, bus_req}, 32'd0);
    chk("late_ack_dm", DM_RD, 32'd0);
    bus_ack = 1'b0;
    @(posedge CLK);
    #1;
    do_access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'h0204_0204, st, bq, id, dm, wok, aok);
    chk("after_rst_dm", dm, 32'h0204_0204);
    chk("after_rst_stall", st, 32'd3);

    // Random accesses against the transaction model.
    m_aerr = 1'b0; m_terr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic        rd, wr;
      logic [31:0] addr, wdata, rdata;
      int          sel, ack_n, gap;
      sel = $urandom_range(0, 2);
      rd = (sel != 1);
      wr = (sel != 0);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      else addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      rdata = $urandom;
      ack_n = $urandom_range(0, 20);
      model(wr, addr, ack_n, rdata, e_dm, e_st, e_bq, e_mis, e_tmo);
      m_aerr = m_aerr | e_mis;
      m_terr = m_terr | e_tmo;
      do_access(rd, wr, addr, wdata, ack_n, rdata, st, bq, id, dm, wok, aok);
      chk($sformatf("r%0d_dm", n), dm, e_dm);
      chk($sformatf("r%0d_stall", n), st, e_st);
      chk($sformatf("r%0d_breq", n), bq, e_bq);
      chk($sformatf("r%0d_we_addr", n), {30'd0, wok, aok}, 32'd3);
      chk($sformatf("r%0d_errs", n), {30'd0, AlignErr, TimeoutErr}, {30'd0, m_aerr, m_terr});
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge CLK);
      #1;
      if (gap != 0) chk($sformatf("r%0d_hold_dm", n), DM_RD, e_dm);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
